// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - vectored interrupt controller: sync, edge/level pending, mask, fixed priority, req/ack/rti handshake
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   irq[N_IRQ]          raw interrupt lines (asynchronous to clk)
//   cfg_we/addr/wdata   register write port: 0=mask, 1=edge_mode, 2=sw_set, 3=pend_clr
//   int_ack, rti        core handshake pulses
//   int_req             request to core int input
//   vec_addr            VEC_BASE + active_id
//   active_id           channel being requested or serviced
//   busy                high while an ISR is in service
//   pending             pending bits
module irq_ctrl #(
    parameter int                N_IRQ    = 4,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] VEC_BASE = 8'h01,
    parameter int                ID_W     = $clog2(N_IRQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [N_IRQ-1:0]  cfg_wdata,
    input  logic              int_ack,
    input  logic              rti,
    output logic              int_req,
    output logic [ADDR_W-1:0] vec_addr,
    output logic [ID_W-1:0]   active_id,
    output logic              busy,
    output logic [N_IRQ-1:0]  pending
);

    localparam logic [1:0] CFG_MASK     = 2'd0;
    localparam logic [1:0] CFG_EDGE     = 2'd1;
    localparam logic [1:0] CFG_SW_SET   = 2'd2;
    localparam logic [1:0] CFG_PEND_CLR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IRQ-1:0]  s1_q, s1_d;
    logic [N_IRQ-1:0]  s2_q, s2_d;
    logic [N_IRQ-1:0]  prev_q, prev_d;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  mask_q, mask_d;
    logic [N_IRQ-1:0]  edge_q, edge_d;
    logic [ID_W-1:0]   active_id_q, active_id_d;
    logic              int_req_q, int_req_d;
    logic              busy_q, busy_d;

    logic [N_IRQ-1:0]  sw_set;
    logic [N_IRQ-1:0]  sw_clr;
    logic [N_IRQ-1:0]  ack_clr;
    logic [N_IRQ-1:0]  edge_pend;
    logic [N_IRQ-1:0]  eligible;
    logic [ID_W-1:0]   low_id;

    always_comb begin
        s1_d   = irq;
        s2_d   = s1_q;
        prev_d = s2_q;

        sw_set  = (cfg_we && cfg_addr == CFG_SW_SET)   ? cfg_wdata : '0;
        sw_clr  = (cfg_we && cfg_addr == CFG_PEND_CLR) ? cfg_wdata : '0;
        ack_clr = '0;
        if (state_q == ST_REQ && int_ack) begin
            ack_clr[active_id_q] = 1'b1;
        end

        // Sets are OR-ed in after clears so a coincident set wins.
        edge_pend = (pending_q & ~(sw_clr | ack_clr)) | (s2_q & ~prev_q) | sw_set;
        // Level channels simply follow the synchronised line.
        pending_d = (edge_pend & edge_q) | (s2_q & ~edge_q);

        mask_d = (cfg_we && cfg_addr == CFG_MASK) ? cfg_wdata : mask_q;
        edge_d = (cfg_we && cfg_addr == CFG_EDGE) ? cfg_wdata : edge_q;

        // Arbitration sees pre-edge register values; lowest index wins.
        eligible = pending_q & mask_q;
        low_id   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                low_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        case (state_q)
            ST_IDLE: begin
                if (eligible != '0) begin
                    state_d     = ST_REQ;
                    active_id_d = low_id;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (rti) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        int_req_d = (state_d == ST_REQ);
        busy_d    = (state_d == ST_SERVICE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s1_q        <= '0;
            s2_q        <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            edge_q      <= '1;
            active_id_q <= '0;
            int_req_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            edge_q      <= edge_d;
            active_id_q <= active_id_d;
            int_req_q   <= int_req_d;
            busy_q      <= busy_d;
        end
    end

    assign int_req   = int_req_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign active_id = active_id_q;
    assign vec_addr  = VEC_BASE + ADDR_W'(active_id_q);

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl with directed scenarios and randomized traffic
module tb_irq_ctrl;

    localparam int                N        = 4;
    localparam int                ADDR_W   = 8;
    localparam logic [ADDR_W-1:0] VEC_BASE = 8'h01;
    localparam int                ID_W     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      irq = '0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_addr = '0;
    logic [N-1:0]      cfg_wdata = '0;
    logic              int_ack = 1'b0;
    logic              rti = 1'b0;
    logic              int_req;
    logic [ADDR_W-1:0] vec_addr;
    logic [ID_W-1:0]   active_id;
    logic              busy;
    logic [N-1:0]      pending;

    irq_ctrl #(
        .N_IRQ   (N),
        .ADDR_W  (ADDR_W),
        .VEC_BASE(VEC_BASE),
        .ID_W    (ID_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .int_ack  (int_ack),
        .rti      (rti),
        .int_req  (int_req),
        .vec_addr (vec_addr),
        .active_id(active_id),
        .busy     (busy),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              int_req;
        logic [ADDR_W-1:0] vec_addr;
        logic [ID_W-1:0]   active_id;
        logic              busy;
        logic [N-1:0]      pending;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp, mon_act;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: line history as a short delay line, mode as 0=idle 1=req 2=service.
    logic [N-1:0] hist [0:2];
    logic [N-1:0] m_pend, m_mask, m_edge;
    int           m_mode, m_id;
    logic [N-1:0] irq_hold = '0;

    task automatic model_step();
        logic [N-1:0] s2, prv, nxt, elig;
        obs_t e;
        if (rst) begin
            for (int h = 0; h < 3; h++) hist[h] = '0;
            m_pend = '0; m_mask = '0; m_edge = '1; m_mode = 0; m_id = 0;
        end else begin
            s2  = hist[1];
            prv = hist[2];
            for (int i = 0; i < N; i++) begin
                if (m_edge[i]) begin
                    nxt[i] = m_pend[i];
                    if (cfg_we && cfg_addr == 2'd3 && cfg_wdata[i]) nxt[i] = 1'b0;
                    if (m_mode == 1 && int_ack && m_id == i)       nxt[i] = 1'b0;
                    if (s2[i] && !prv[i])                          nxt[i] = 1'b1;
                    if (cfg_we && cfg_addr == 2'd2 && cfg_wdata[i]) nxt[i] = 1'b1;
                end else begin
                    nxt[i] = s2[i];
                end
            end
            elig = m_pend & m_mask;
            if (m_mode == 0) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (elig[i]) begin
                        m_id   = i;
                        m_mode = 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (int_ack) m_mode = 2;
            end else begin
                if (rti) m_mode = 0;
            end
            if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
            if (cfg_we && cfg_addr == 2'd1) m_edge = cfg_wdata;
            m_pend  = nxt;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq;
        end
        e.int_req   = (m_mode == 1);
        e.busy      = (m_mode == 2);
        e.active_id = ID_W'(m_id);
        e.vec_addr  = ADDR_W'((int'(VEC_BASE) + m_id) % (1 << ADDR_W));
        e.pending   = m_pend;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] i, input logic we,
                       input logic [1:0] a, input logic [N-1:0] d,
                       input logic k, input logic t);
        @(negedge clk);
        rst = r; irq = i; cfg_we = we; cfg_addr = a; cfg_wdata = d;
        int_ack = k; rti = t;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cyc(1'b0, irq_hold, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [1:0] a, input logic [N-1:0] d);
        cyc(1'b0, irq_hold, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic ack();
        cyc(1'b0, irq_hold, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    endtask

    task automatic ret();
        cyc(1'b0, irq_hold, 1'b0, 2'd0, '0, 1'b0, 1'b1);
    endtask

    task automatic pulse(input logic [N-1:0] b);
        irq_hold = b;
        idle(1);
        irq_hold = '0;
    endtask

    task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act.int_req   = int_req;
            mon_act.vec_addr  = vec_addr;
            mon_act.active_id = active_id;
            mon_act.busy      = busy;
            mon_act.pending   = pending;
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL outputs @%0t: got req=%b vec=%h id=%0d busy=%b pend=%b, required req=%b vec=%h id=%0d busy=%b pend=%b",
                         $time, mon_act.int_req, mon_act.vec_addr, mon_act.active_id, mon_act.busy, mon_act.pending,
                         mon_exp.int_req, mon_exp.vec_addr, mon_exp.active_id, mon_exp.busy, mon_exp.pending);
            end
        end
    end

    logic [N-1:0] flip;

    initial begin
        for (int h = 0; h < 3; h++) hist[h] = '0;
        m_pend = '0; m_mask = '0; m_edge = '1; m_mode = 0; m_id = 0;

        repeat (2) cyc(1'b1, '0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
        idle(1);
        cfg(2'd0, 4'hF);
        cfg(2'd1, 4'hF);

        // Single edge on channel 2, full handshake.
        pulse(4'b0100); idle(4); ack(); idle(2); ret(); idle(3);

        // Simultaneous edges on 3 and 1: 1 first, then 3.
        pulse(4'b1010); idle(4); ack(); idle(1); ret(); idle(4); ack(); idle(1); ret(); idle(2);

        // Masked channel 0 pends without request until unmasked.
        cfg(2'd0, 4'b1110); pulse(4'b0001); idle(4);
        cfg(2'd0, 4'hF); idle(2); ack(); idle(1); ret(); idle(2);

        // Level channel 1: re-request while held, none after drop.
        cfg(2'd1, 4'b1101);
        irq_hold = 4'b0010; idle(4); ack(); idle(2); ret(); idle(3);
        ack(); irq_hold = '0; idle(3); ret(); idle(3);
        cfg(2'd1, 4'hF);

        // New edge on active channel 2 coincident with int_ack.
        pulse(4'b0100); idle(4);
        pulse(4'b0100); idle(1); ack(); idle(2); ret(); idle(4); ack(); idle(1); ret(); idle(2);

        // sw_set then pend_clr on a masked channel, then unmask: no request.
        cfg(2'd0, 4'b1011); cfg(2'd2, 4'b0100); cfg(2'd3, 4'b0100); idle(2);
        cfg(2'd0, 4'hF); idle(3);
        cfg(2'd2, 4'b0100); idle(2); ack(); idle(1); ret(); idle(2);

        // Asynchronous reset mid-service.
        pulse(4'b0001); idle(4); ack(); idle(1);
        #3;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk1("async_int_req", 32'(int_req), 32'd0);
        chk1("async_busy", 32'(busy), 32'd0);
        chk1("async_pending", 32'(pending), 32'd0);
        chk1("async_active_id", 32'(active_id), 32'd0);
        chk1("async_vec_addr", 32'(vec_addr), 32'(VEC_BASE));
        repeat (2) cyc(1'b1, '0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
        idle(1);
        pulse(4'b1111); idle(5); ack(); idle(2);
        cfg(2'd0, 4'hF); idle(3); ack(); idle(1); ret(); idle(6);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(7) == 0);
            irq_hold = irq_hold ^ flip;
            cyc(1'b0, irq_hold, ($urandom_range(5) == 0), 2'($urandom_range(3)),
                N'($urandom), ($urandom_range(2) == 0), ($urandom_range(3) == 0));
        end

        @(negedge clk);
        #1;
        chk1("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Parametrised vectored interrupt controller between N peripheral interrupt lines and the single `int` input of the 8-bit pipelined core. It adds synchronisation, per-channel edge/level mode, masking, fixed priority and a request/acknowledge/return handshake. It also supplies the memory address of the selected channel's ISR vector. The core fetches the ISR start PC from that address instead of the single fixed vector at M[1].

## Interface
- `N_IRQ`, 4, number of interrupt channels (2..8)
- `ADDR_W`, 8, width of vector address
- `VEC_BASE`, 8'h01, memory address of channel 0's vector; channel i uses VEC_BASE+i
- `ID_W`, $clog2(N_IRQ), channel-index width (derived)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `irq`  in  N_IRQ  raw interrupt lines, may be asynchronous
- `cfg_we`  in  1  config write strobe, one write per cycle
- `cfg_addr`  in  2  0=mask, 1=edge_mode, 2=sw_set, 3=pend_clr
- `cfg_wdata`  in  N_IRQ  config write data
- `int_ack`  in  1  core took the interrupt (1-cycle pulse)
- `rti`  in  1  core retired RTI (1-cycle pulse)
- `int_req`  out  1  interrupt request to core `int`
- `vec_addr`  out  ADDR_W  VEC_BASE + active_id, mod 2^ADDR_W
- `active_id`  out  ID_W  channel being requested or serviced
- `busy`  out  1  high in SERVICE
- `pending`  out  N_IRQ  pending bits

## Operation
- Each `irq` bit passes through a 2-flop synchroniser (s1→s2). A third flop `prev` holds s2 delayed.
- Edge channel (edge_mode=1): pending[i] set on s2 & ~prev. Cleared by int_ack when the channel is active_id, or by a pend_clr write. If a set and a clear occur in the same cycle, set wins.
- Level channel (edge_mode=0): pending[i] = s2. sw_set and pend_clr have no effect on level channels.
- sw_set write: pending |= cfg_wdata & edge_mode. pend_clr write: pending &= ~(cfg_wdata & edge_mode).
- mask: 1 = enabled. eligible = pending & mask. The lowest index has the highest priority.
- FSM IDLE / REQ / SERVICE:
  - IDLE: if eligible≠0, latch active_id = lowest set bit and go to REQ. If eligible=0, stay in IDLE.
  - REQ: int_req=1, and active_id and vec_addr are frozen. A mask change or a deasserting level source does not withdraw the request. On int_ack, clear pending[active_id] if it is an edge channel, then go to SERVICE. rti is ignored in this state.
  - SERVICE: int_req=0, busy=1, no nesting. On rti, go to IDLE. int_ack is ignored.
- int_ack in IDLE and rti in IDLE are ignored.
- New edges continue to be captured in all states.
- Reset (asynchronous, takes effect at any point mid-operation):
  - state = IDLE.
  - int_req=0, busy=0, active_id=0, vec_addr=VEC_BASE.
  - pending=0, mask=0 (all disabled), edge_mode=all 1.
  - Synchroniser and prev flops = 0.

## Timing
- External edge on irq before posedge k: s1=1 after k, s2=1 after k+1, pending=1 after k+2, state=REQ and int_req=1 after k+3. Latency is 3 clocks.
- sw_set write at posedge k: pending=1 after k, int_req=1 after k+1.
- int_ack sampled at posedge k: int_req=0 and busy=1 after k.
- rti at posedge k: IDLE after k. If eligible≠0, int_req=1 again after k+1. One bubble cycle is guaranteed between back-to-back services.
- A config write takes effect on the edge it is sampled. IDLE arbitration uses the register values from before that edge.
- All outputs are registered, except vec_addr, which is a combinational add on registered active_id.

## Test plan
- Reset, then mask=4'hF and edge_mode=4'hF. Pulse irq[2] for 1 cycle at posedge k → int_req=1 after k+3, active_id=2, vec_addr=8'h03. int_ack → busy=1, pending[2]=0. rti → IDLE, int_req stays 0.
- Edges on irq[3] and irq[1] in the same cycle → active_id=1 first. After int_ack and rti, int_req rises again with active_id=3 and vec_addr=8'h04.
- mask=4'b1110, pulse irq[0] → pending[0]=1 and int_req stays 0. Write mask=4'hF → int_req=1 after 1 cycle, active_id=0.
- edge_mode[1]=0, hold irq[1] high → REQ, ack, SERVICE. rti with irq[1] still high → int_req=1 again after 1 bubble cycle. Drop irq[1] during SERVICE → pending[1]=0 two cycles after the drop, no re-request after rti.
- Edge on active channel 2 in the same cycle as int_ack → pending[2] remains 1, and a second service follows rti. Also: sw_set=4'b0100 then pend_clr=4'b0100 before arbitration → int_req stays 0.
- Assert rst mid-SERVICE → int_req=0, busy=0, pending=0, mask=0 immediately, without waiting for a clock. After release, irq activity is ignored until mask is written.
